// File: rtl/btn_cond_pkg.sv
// Shared definitions for the push-button conditioner: channel FSM state codes and width helpers.
// Latency: n/a (constants and elaboration-time functions only).
// Backpressure: n/a.
package btn_cond_pkg;

    // Channel FSM state encoding (3 bits)
    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE         = 3'd0;
    localparam state_t ST_PRESS_QUAL   = 3'd1;
    localparam state_t ST_SCEN         = 3'd2;
    localparam state_t ST_HOLD_DELAY   = 3'd3;
    localparam state_t ST_MCEN         = 3'd4;
    localparam state_t ST_HOLD_REPEAT  = 3'd5;
    localparam state_t ST_RELEASE_QUAL = 3'd6;

    // Bits needed to hold the values 0 .. value-1 (never less than one bit)
    function automatic int clog2(input int value);
        int bits;
        int rem;
        bits = 0;
        rem  = value - 1;
        while (rem > 0) begin
            bits = bits + 1;
            rem  = rem >> 1;
        end
        if (bits < 1) begin
            bits = 1;
        end
        return bits;
    endfunction

    // Largest of three values; sizes the shared per-channel counter
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return m;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchroniser, debounce/auto-repeat FSM and its shared cycle counter.
// Latency: press accepted DEBOUNCE_CYCLES+2 edges after btn_in is first sampled high; release likewise.
// Backpressure: none; outputs are free-running pulses/levels decoded from the registered state.
module btn_channel
    import btn_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000,
    parameter int CNT_W           = clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD))
) (
    input  logic ClkPort,
    input  logic reset,
    input  logic btn_in,
    output logic dpb,
    output logic scen,
    output logic mcen
);

    // Terminal counts: a state is left on the cycle its counter shows N-1
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sync;

    assign sync = sync2_q;

    // Synchroniser next values: the raw pin goes through two flops before the FSM sees it
    always_comb begin
        sync1_d = btn_in;
        sync2_d = sync1_q;
    end

    // Next-state logic; a low sync always wins over a terminal count while holding
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (sync) begin
                    state_d = ST_PRESS_QUAL;
                end
            end
            ST_PRESS_QUAL: begin
                if (!sync) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = ST_SCEN;
                end
            end
            ST_SCEN: begin
                state_d = ST_HOLD_DELAY;
            end
            ST_HOLD_DELAY: begin
                if (!sync) begin
                    state_d = ST_RELEASE_QUAL;
                end else if (cnt_q == DLY_LAST) begin
                    state_d = ST_MCEN;
                end
            end
            ST_MCEN: begin
                state_d = ST_HOLD_REPEAT;
            end
            ST_HOLD_REPEAT: begin
                if (!sync) begin
                    state_d = ST_RELEASE_QUAL;
                end else if (cnt_q == PER_LAST) begin
                    state_d = ST_MCEN;
                end
            end
            ST_RELEASE_QUAL: begin
                // A short low blip while held is absorbed: back to repeating, no new press pulse
                if (sync) begin
                    state_d = ST_HOLD_REPEAT;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Counter restarts on every state change and otherwise counts cycles spent in the state
    always_comb begin
        if (state_d != state_q) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Moore outputs decoded straight from the registered state
    always_comb begin
        dpb  = (state_q == ST_SCEN)       || (state_q == ST_HOLD_DELAY)  ||
               (state_q == ST_MCEN)       || (state_q == ST_HOLD_REPEAT) ||
               (state_q == ST_RELEASE_QUAL);
        scen = (state_q == ST_SCEN);
        mcen = (state_q == ST_SCEN) || (state_q == ST_MCEN);
    end

    // State, counter and synchroniser registers; reset forces IDLE so outputs drop at once
    always_ff @(posedge ClkPort or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/btn_conditioner_n.sv
// N-channel push-button front end: per-channel debounce/press/auto-repeat plus a shared continuous-rate enable.
// Latency: dpb/scen/mcen straight from channel state; ccen registered, one cycle behind the prescaler tick.
// Backpressure: none; the prescaler free-runs and is never disturbed by button activity.
module btn_conditioner_n
    import btn_cond_pkg::*;
#(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000,
    parameter int CCEN_PERIOD     = 2500000
) (
    input  logic             ClkPort,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] dpb,
    output logic [N_BTN-1:0] scen,
    output logic [N_BTN-1:0] mcen,
    output logic [N_BTN-1:0] ccen
);

    localparam int CNT_W = clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD));
    localparam int PRE_W = clog2(CCEN_PERIOD);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CCEN_PERIOD - 1);

    logic [N_BTN-1:0] dpb_w;
    logic [N_BTN-1:0] scen_w;
    logic [N_BTN-1:0] mcen_w;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [N_BTN-1:0] ccen_q, ccen_d;
    logic             tick;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .CNT_W           (CNT_W)
        ) u_ch (
            .ClkPort (ClkPort),
            .reset   (reset),
            .btn_in  (btn_in[i]),
            .dpb     (dpb_w[i]),
            .scen    (scen_w[i]),
            .mcen    (mcen_w[i])
        );
    end

    // Shared prescaler wraps 0..CCEN_PERIOD-1; tick marks its last count
    always_comb begin
        tick  = (pre_q == PRE_LAST);
        pre_d = tick ? '0 : pre_q + 1'b1;
    end

    // Continuous enable: the tick gated by each channel's debounced level
    always_comb begin
        ccen_d = {N_BTN{tick}} & dpb_w;
    end

    // Prescaler and ccen output registers
    always_ff @(posedge ClkPort or posedge reset) begin
        if (reset) begin
            pre_q  <= '0;
            ccen_q <= '0;
        end else begin
            pre_q  <= pre_d;
            ccen_q <= ccen_d;
        end
    end

    assign dpb  = dpb_w;
    assign scen = scen_w;
    assign mcen = mcen_w;
    assign ccen = ccen_q;

endmodule
